call_request_scheduler: RTL and testbench

- Upstream stage of the elevator controller. Captures cabin (interior) and hall (exterior) floor-button presses and latches them as pending calls.
- Serialises the pending calls into the 3-bit movement codes the controller consumes: 3'b000 means no request, 3'b001..3'b111 mean floors 1..7. Each code is a one-cycle pulse.
- Also drives per-floor pending lamps.

---
 rtl/elevator_pkg.sv | 44 ++++
 rtl/call_channel.sv | 127 ++++++++++++
 rtl/call_request_scheduler.sv | 41 ++++
 tb/tb_call_request_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants, scanner state encoding and round-robin helpers for the
// elevator call scheduler.
package elevator_pkg;

  localparam int         FLOOR_COUNT = 7;
  localparam logic [2:0] CODE_NONE   = 3'b000;
  localparam logic [2:0] LAST_RESET  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EMIT = ST_EMIT,
    S_GAP  = ST_GAP
  } scan_state_t;

  // First pending floor strictly after 'last', wrapping 7 -> 1; CODE_NONE if none pending.
  function automatic logic [2:0] next_rr(input logic [FLOOR_COUNT-1:0] pending,
                                         input logic [2:0]             last);
    logic [2:0] code;
    logic [2:0] floor;
    code  = CODE_NONE;
    floor = last;
    for (int k = 0; k < FLOOR_COUNT; k++) begin
      floor = (floor == 3'd7) ? 3'd1 : floor + 3'd1;
      if (code == CODE_NONE && pending[floor - 3'd1]) begin
        code = floor;
      end
    end
    return code;
  endfunction

  function automatic logic [FLOOR_COUNT-1:0] floor_bit(input logic [2:0] code);
    logic [FLOOR_COUNT-1:0] mask;
    mask = '0;
    if (code != CODE_NONE) begin
      mask[code - 3'd1] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/call_channel.sv
// One call channel: press detect (optional debounce under CALL_DEBOUNCE_EN),
// pending-call register and the round-robin scanner that emits one-cycle codes.
module call_channel
  import elevator_pkg::*;
#(
  parameter int GAP_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [FLOOR_COUNT-1:0] i_buttons,
  output logic [2:0]             o_movement,
  output logic [FLOOR_COUNT-1:0] o_pending
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  if (GAP_CYCLES < 0 || GAP_CYCLES > 15 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_param_check
    $error("call_channel: GAP_CYCLES or DEBOUNCE_CYCLES out of range");
  end

  logic [FLOOR_COUNT-1:0] w_level;
  logic [FLOOR_COUNT-1:0] w_press;
  logic [FLOOR_COUNT-1:0] w_clear;
  logic [2:0]             w_pick;

  logic [FLOOR_COUNT-1:0] r_hist;
  logic [FLOOR_COUNT-1:0] r_pending;
  scan_state_t            r_state;
  logic [3:0]             r_gap_cnt;
  logic [2:0]             r_last;
  logic [2:0]             r_movement;

`ifdef CALL_DEBOUNCE_EN
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  // The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  genvar gi;
  generate
    for (gi = 0; gi < FLOOR_COUNT; gi++) begin : g_debounce
      logic [3:0] r_cnt;
      logic       r_stable;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (i_buttons[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt >= DB_LAST) begin
          r_stable <= i_buttons[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end

      assign w_level[gi] = r_stable;
    end
  endgenerate
`else
  assign w_level = i_buttons;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_level;
    end
  end

  assign w_press = w_level & ~r_hist;
  assign w_pick  = next_rr(r_pending, r_last);
  assign w_clear = (r_state == S_IDLE) ? floor_bit(w_pick) : '0;

  // A press landing on the bit being served keeps it pending.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_press;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_last     <= LAST_RESET;
      r_movement <= CODE_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick != CODE_NONE) begin
            r_movement <= w_pick;
            r_last     <= w_pick;
            r_state    <= S_EMIT;
          end else begin
            r_movement <= CODE_NONE;
          end
        end
        S_EMIT: begin
          r_movement <= CODE_NONE;
          r_gap_cnt  <= GAP_LOAD;
          r_state    <= (GAP_LOAD == 4'd0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          r_movement <= CODE_NONE;
          r_gap_cnt  <= r_gap_cnt - 4'd1;
          if (r_gap_cnt <= 4'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_movement <= CODE_NONE;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign o_movement = r_movement;
  assign o_pending  = r_pending;

endmodule

// File: rtl/call_request_scheduler.sv
// Elevator call scheduler: independent cabin and hall call channels.
// Build with CALL_DEBOUNCE_EN defined to debounce every button input.
module call_request_scheduler
  import elevator_pkg::*;
#(
  parameter int GAP_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [FLOOR_COUNT-1:0] interior_buttons,
  input  logic [FLOOR_COUNT-1:0] exterior_buttons,
  output logic [2:0]             interior_movement,
  output logic [2:0]             exterior_movement,
  output logic [FLOOR_COUNT-1:0] interior_pending,
  output logic [FLOOR_COUNT-1:0] exterior_pending
);

  call_channel #(
    .GAP_CYCLES      (GAP_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_interior (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_buttons  (interior_buttons),
    .o_movement (interior_movement),
    .o_pending  (interior_pending)
  );

  call_channel #(
    .GAP_CYCLES      (GAP_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_exterior (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_buttons  (exterior_buttons),
    .o_movement (exterior_movement),
    .o_pending  (exterior_pending)
  );

endmodule

// File: tb/tb_call_request_scheduler.sv
// Directed bench for call_request_scheduler (GAP_CYCLES=4, DEBOUNCE_CYCLES=3).
module tb_call_request_scheduler;

`ifdef CALL_DEBOUNCE_EN
  localparam int DB = 3;
`else
  localparam int DB = 0;
`endif
  localparam int HOLD = (DB == 0) ? 1 : DB;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] ib  = '0;
  logic [6:0] eb  = '0;
  logic [2:0] interior_movement;
  logic [2:0] exterior_movement;
  logic [6:0] interior_pending;
  logic [6:0] exterior_pending;

  call_request_scheduler #(
    .GAP_CYCLES      (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .interior_buttons  (ib),
    .exterior_buttons  (eb),
    .interior_movement (interior_movement),
    .exterior_movement (exterior_movement),
    .interior_pending  (interior_pending),
    .exterior_pending  (exterior_pending)
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         t0;
  int         t1;
  logic [2:0] in_codes[$];
  int         in_times[$];
  logic [2:0] ex_codes[$];
  int         ex_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to negedge number t, logging every nonzero code with its cycle.
  task automatic run_to(input int t);
    while (cyc < t) begin
      @(negedge CLK);
      cyc++;
      if (interior_movement !== 3'b000) begin
        in_codes.push_back(interior_movement);
        in_times.push_back(cyc);
      end
      if (exterior_movement !== 3'b000) begin
        ex_codes.push_back(exterior_movement);
        ex_times.push_back(cyc);
      end
    end
  endtask

  task automatic clear_q();
    in_codes.delete(); in_times.delete();
    ex_codes.delete(); ex_times.delete();
  endtask

  task automatic do_reset();
    RST = 1'b0; ib = '0; eb = '0;
    run_to(cyc + 2);
    RST = 1'b1;
    clear_q();
  endtask

  function automatic logic [2:0] in_code(input int i);
    return (i < in_codes.size()) ? in_codes[i] : 3'bxxx;
  endfunction
  function automatic int in_time(input int i);
    return (i < in_times.size()) ? in_times[i] : -1;
  endfunction
  function automatic logic [2:0] ex_code(input int i);
    return (i < ex_codes.size()) ? ex_codes[i] : 3'bxxx;
  endfunction
  function automatic int ex_time(input int i);
    return (i < ex_times.size()) ? ex_times[i] : -1;
  endfunction

  initial begin
    // reset state
    RST = 1'b0;
    run_to(3);
    chk("rst_in_mov", 32'(interior_movement), 32'd0);
    chk("rst_ex_mov", 32'(exterior_movement), 32'd0);
    chk("rst_in_pend", 32'(interior_pending), 32'd0);
    chk("rst_ex_pend", 32'(exterior_pending), 32'd0);
    $display("step reset: outputs idle");

    // single interior press, floor 2
    do_reset();
    t0 = cyc; ib = 7'b0000010;
    run_to(t0 + HOLD); ib = '0;
    run_to(t0 + 1 + DB);
    chk("t1_pend_set", 32'(interior_pending), 32'h02);
    chk("t1_mov_before", 32'(interior_movement), 32'd0);
    run_to(t0 + 2 + DB);
    chk("t1_mov_code", 32'(interior_movement), 32'h2);
    chk("t1_pend_drop", 32'(interior_pending), 32'd0);
    run_to(t0 + 3 + DB);
    chk("t1_mov_after", 32'(interior_movement), 32'd0);
    run_to(t0 + 12 + DB);
    chk("t1_count", 32'(in_codes.size()), 32'd1);
    $display("step single press: %0d code(s)", in_codes.size());

    // floors 1,3,5 together: round-robin from floor 1, six cycles apart
    do_reset();
    t0 = cyc; ib = 7'b0010101;
    run_to(t0 + HOLD); ib = '0;
    run_to(t0 + 1 + DB);
    chk("t2_pend_set", 32'(interior_pending), 32'h15);
    run_to(t0 + 2 + DB);
    chk("t2_pend_after1", 32'(interior_pending), 32'h14);
    run_to(t0 + 25 + DB);
    chk("t2_count", 32'(in_codes.size()), 32'd3);
    chk("t2_code0", 32'(in_code(0)), 32'h1);
    chk("t2_code1", 32'(in_code(1)), 32'h3);
    chk("t2_code2", 32'(in_code(2)), 32'h5);
    chk("t2_time0", 32'(in_time(0)), 32'(t0 + 2 + DB));
    chk("t2_time1", 32'(in_time(1)), 32'(t0 + 8 + DB));
    chk("t2_time2", 32'(in_time(2)), 32'(t0 + 14 + DB));
    $display("step three floors: %0d code(s)", in_codes.size());

    // hold exterior floor 7 for 30 cycles, then release and re-press
    do_reset();
    t0 = cyc; eb = 7'b1000000;
    run_to(t0 + 30); eb = '0;
    run_to(t0 + 45);
    chk("t3_hold_count", 32'(ex_codes.size()), 32'd1);
    chk("t3_hold_code", 32'(ex_code(0)), 32'h7);
    t1 = cyc; eb = 7'b1000000;
    run_to(t1 + HOLD); eb = '0;
    run_to(t1 + 12 + DB);
    chk("t3_repress_count", 32'(ex_codes.size()), 32'd2);
    chk("t3_repress_code", 32'(ex_code(1)), 32'h7);
    chk("t3_repress_time", 32'(ex_time(1)), 32'(t1 + 2 + DB));
    chk("t3_in_quiet", 32'(in_codes.size()), 32'd0);
    $display("step hold floor 7: %0d code(s)", ex_codes.size());

`ifndef CALL_DEBOUNCE_EN
    // re-press floor 2 during its emit, then again on the load edge (set beats clear)
    do_reset();
    t0 = cyc; ib = 7'b0000010;
    run_to(t0 + 1); ib = '0;
    run_to(t0 + 2);
    chk("t4_mov_first", 32'(interior_movement), 32'h2);
    chk("t4_pend_cleared", 32'(interior_pending), 32'd0);
    ib = 7'b0000010;
    run_to(t0 + 3); ib = '0;
    chk("t4_pend_merge", 32'(interior_pending), 32'h02);
    run_to(t0 + 7); ib = 7'b0000010;
    run_to(t0 + 8); ib = '0;
    chk("t4_mov_second", 32'(interior_movement), 32'h2);
    chk("t4_set_wins", 32'(interior_pending), 32'h02);
    run_to(t0 + 22);
    chk("t4_count", 32'(in_codes.size()), 32'd3);
    chk("t4_time1", 32'(in_time(1)), 32'(t0 + 8));
    chk("t4_time2", 32'(in_time(2)), 32'(t0 + 14));
    chk("t4_code2", 32'(in_code(2)), 32'h2);
    $display("step re-press during emit: %0d code(s)", in_codes.size());
`endif

    // both channels pressed together
    do_reset();
    t0 = cyc; ib = 7'b0001000; eb = 7'b0100000;
    run_to(t0 + HOLD); ib = '0; eb = '0;
    run_to(t0 + 10 + DB);
    chk("t5_in_code", 32'(in_code(0)), 32'h4);
    chk("t5_ex_code", 32'(ex_code(0)), 32'h6);
    chk("t5_same_cycle", 32'(ex_time(0)), 32'(in_time(0)));
    chk("t5_time", 32'(in_time(0)), 32'(t0 + 2 + DB));
    $display("step both channels: in=%0d ex=%0d", in_code(0), ex_code(0));

    // reset during GAP with calls queued on both channels
    do_reset();
    t0 = cyc; ib = 7'b1010101; eb = 7'b0001111;
    run_to(t0 + HOLD); ib = '0; eb = '0;
    run_to(t0 + 2 + DB);
    chk("t6_first_code", 32'(interior_movement), 32'h1);
    chk("t6_pend_left", 32'(interior_pending), 32'h54);
    run_to(t0 + 4 + DB);
    RST = 1'b0;
    run_to(t0 + 5 + DB);
    chk("t6_rst_in_mov", 32'(interior_movement), 32'd0);
    chk("t6_rst_ex_mov", 32'(exterior_movement), 32'd0);
    chk("t6_rst_in_pend", 32'(interior_pending), 32'd0);
    chk("t6_rst_ex_pend", 32'(exterior_pending), 32'd0);
    RST = 1'b1;
    clear_q();
    run_to(t0 + 35 + DB);
    chk("t6_lost_in", 32'(in_codes.size()), 32'd0);
    chk("t6_lost_ex", 32'(ex_codes.size()), 32'd0);
    $display("step reset during gap: codes after release in=%0d ex=%0d", in_codes.size(), ex_codes.size());

    // button held through reset release
    RST = 1'b0; ib = 7'b0100000;
    run_to(cyc + 3);
    t0 = cyc; RST = 1'b1;
    clear_q();
    run_to(t0 + 30);
    chk("t7_count", 32'(in_codes.size()), 32'd1);
    chk("t7_code", 32'(in_code(0)), 32'h6);
    chk("t7_time", 32'(in_time(0)), 32'(t0 + 2 + DB));
    ib = '0;
    run_to(cyc + 10);
    $display("step held through reset: %0d code(s)", in_codes.size());

`ifdef CALL_DEBOUNCE_EN
    // two-cycle glitch ignored, three-cycle hold accepted
    do_reset();
    t0 = cyc; ib = 7'b0000100;
    run_to(t0 + 2); ib = '0;
    run_to(t0 + 20);
    chk("db_glitch", 32'(in_codes.size()), 32'd0);
    t1 = cyc; ib = 7'b0000100;
    run_to(t1 + 3); ib = '0;
    run_to(t1 + 4);
    chk("db_pend", 32'(interior_pending), 32'h04);
    run_to(t1 + 20);
    chk("db_count", 32'(in_codes.size()), 32'd1);
    chk("db_time", 32'(in_time(0)), 32'(t1 + 5));
    $display("step debounce: %0d code(s)", in_codes.size());
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
